// File: rtl/frame_generator_sequencer.sv
// frame_generator_sequencer: run-control sequencer for the frame generator.
// Takes one host command at a time and walks it through ARM -> RUN -> STOP.
// It waits for gen_ready, pulses gen_start, times the run, pulses gen_stop and
// waits for the generator to come back to ready. Every output is registered.
// Optional frame counter: define FRAME_GEN_SEQ_FRAME_COUNT_EN to build it;
// otherwise frame_count is tied to 0 and the mon_* tap is unused.
module frame_generator_sequencer #(
   parameter int unsigned DURATION_WIDTH = 48,
   parameter int unsigned CNT_WIDTH      = 48,
   localparam int unsigned CFG_WIDTH     = 192
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [DURATION_WIDTH-1:0] cmd_duration,
   input  logic [CFG_WIDTH-1:0]      cmd_port_config,
   input  logic                      abort,
   input  logic                      gen_ready,
   output logic                      gen_start,
   output logic                      gen_stop,
   output logic [CFG_WIDTH-1:0]      gen_port_config,
   input  logic                      mon_valid,
   input  logic                      mon_ready,
   input  logic                      mon_last,
   output logic                      busy,
   output logic                      done,
   output logic                      aborted,
   output logic [DURATION_WIDTH-1:0] elapsed,
   output logic [CNT_WIDTH-1:0]      frame_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_RUN  = 3'd2,
      S_STOP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;

   logic                      r_cmd_ready;
   logic                      r_busy;
   logic                      r_gen_start;
   logic                      r_gen_stop;
   logic                      r_done;
   logic                      r_aborted;
   logic [DURATION_WIDTH-1:0] r_elapsed;
   logic [DURATION_WIDTH-1:0] r_duration;
   logic [CFG_WIDTH-1:0]      r_port_config;

   logic                      w_run_end;
   logic                      w_accept;
   logic                      w_gen_start_nxt;
   logic                      w_gen_stop_nxt;
   logic                      w_set_aborted;
   logic                      w_elapsed_inc;

   // Run ends when the programmed duration is reached or the host aborts
   assign w_run_end = (r_elapsed == r_duration) || abort;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic; STOP ignores gen_ready during the gen_stop pulse cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (cmd_valid && r_cmd_ready) w_state_nxt = S_ARM;
         S_ARM: begin
            if (abort)          w_state_nxt = S_DONE;
            else if (gen_ready) w_state_nxt = S_RUN;
         end
         S_RUN:  if (w_run_end) w_state_nxt = S_STOP;
         S_STOP: if (gen_ready && !r_gen_stop) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath decode: next values for the registered outputs
   always_comb begin
      w_accept        = 1'b0;
      w_gen_start_nxt = 1'b0;
      w_gen_stop_nxt  = 1'b0;
      w_set_aborted   = 1'b0;
      w_elapsed_inc   = 1'b0;
      case (r_state)
         S_IDLE: w_accept = cmd_valid && r_cmd_ready;
         S_ARM: begin
            if (abort)          w_set_aborted   = 1'b1;
            else if (gen_ready) w_gen_start_nxt = 1'b1;
         end
         S_RUN: begin
            if (w_run_end) begin
               w_gen_stop_nxt = 1'b1;
               w_set_aborted  = abort;
            end else begin
               w_elapsed_inc  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs, command latch and elapsed timer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cmd_ready   <= 1'b0;
         r_busy        <= 1'b0;
         r_gen_start   <= 1'b0;
         r_gen_stop    <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_elapsed     <= '0;
         r_duration    <= '0;
         r_port_config <= '0;
      end else begin
         r_cmd_ready <= (w_state_nxt == S_IDLE);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         r_gen_start <= w_gen_start_nxt;
         r_gen_stop  <= w_gen_stop_nxt;
         if (w_accept) begin
            r_duration    <= cmd_duration;
            r_port_config <= cmd_port_config;
            r_elapsed     <= '0;
            r_aborted     <= 1'b0;
         end else begin
            if (w_set_aborted) r_aborted <= 1'b1;
            if (w_elapsed_inc) r_elapsed <= r_elapsed + DURATION_WIDTH'(1);
         end
      end
   end

   assign cmd_ready       = r_cmd_ready;
   assign busy            = r_busy;
   assign gen_start       = r_gen_start;
   assign gen_stop        = r_gen_stop;
   assign done            = r_done;
   assign aborted         = r_aborted;
   assign elapsed         = r_elapsed;
   assign gen_port_config = r_port_config;

`ifdef FRAME_GEN_SEQ_FRAME_COUNT_EN
   logic [CNT_WIDTH-1:0] r_frame_count;
   logic                 w_beat;

   // Frames that complete during RUN or while draining in STOP
   assign w_beat = mon_valid && mon_ready && mon_last &&
                   ((r_state == S_RUN) || (r_state == S_STOP));

   // Saturating frame counter, cleared on accept
   always_ff @(posedge clk) begin
      if (!rst)                                  r_frame_count <= '0;
      else if (w_accept)                         r_frame_count <= '0;
      else if (w_beat && (r_frame_count != '1))  r_frame_count <= r_frame_count + CNT_WIDTH'(1);
   end

   assign frame_count = r_frame_count;
`else
   logic w_unused_mon;
   assign w_unused_mon = &{1'b0, mon_valid, mon_ready, mon_last};
   assign frame_count  = '0;
`endif

endmodule

// File: doc/frame_generator_sequencer.md
# frame_generator_sequencer

Run-control sequencer for the frame generator. Accepts one test command at a time: a port configuration and a run duration in clock cycles. It waits for the generator's `ready`, pulses `start`, times the run, pulses `stop`, then waits for the generator to return to `ready`. It sits between the host control registers and the generator's control inputs, and passively taps the generator's AXIS output to count emitted frames.

## Interface
- `DURATION_WIDTH`, 48, width of run duration and elapsed counter
- `CNT_WIDTH`, 48, width of frame counter

- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  host command valid
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_duration`  in  DURATION_WIDTH  run length in cycles
- `cmd_port_config`  in  192  generator port configuration
- `abort`  in  1  host request to end the run early
- `gen_ready`  in  1  generator `ready`
- `gen_start`  out  1  one-cycle start pulse to generator
- `gen_stop`  out  1  one-cycle stop pulse to generator
- `gen_port_config`  out  192  latched configuration, stable from accept to DONE
- `mon_valid` / `mon_ready` / `mon_last`  in  1 each  tap of generator AXIS output handshake
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `aborted`  out  1  sticky; set if the last run ended via `abort`; cleared on next accept
- `elapsed`  out  DURATION_WIDTH  cycles spent in RUN for the current or last run
- `frame_count`  out  CNT_WIDTH  frames emitted in the current or last run

## Operation
- States: IDLE, ARM, RUN, STOP, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch duration and config, clear `elapsed`, `frame_count` and `aborted`, then go to ARM.
  - `abort` is ignored in IDLE.
- ARM:
  - If `abort`, set `aborted` and go to DONE without pulsing `gen_start`. `abort` has priority over `gen_ready`.
  - Else if `gen_ready`, register `gen_start`=1 for exactly one cycle and go to RUN.
- RUN:
  - `elapsed` increments by 1 each cycle.
  - When `elapsed == duration` or `abort` is high, register `gen_stop`=1 for one cycle and go to STOP. `abort` also sets `aborted`.
  - Duration 0: stop is issued on the first RUN cycle.
- STOP:
  - Wait for `gen_ready`=1, sampled no earlier than the cycle after the `gen_stop` pulse, then go to DONE.
  - `abort` is ignored.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `elapsed` holds its final value until the next accept. It cannot wrap because RUN exits at `duration`.
- Frame counting: `frame_count` increments on every cycle with `mon_valid & mon_ready & mon_last` while state is RUN or STOP, so frames draining after stop are counted. It saturates at all-ones.
- `gen_start` and `gen_stop` are never high in the same cycle, and each is never high for two consecutive cycles.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - Forces IDLE.
  - Sets all outputs to 0, including `cmd_ready`, `gen_port_config`, `elapsed`, `frame_count` and `aborted`.
  - `cmd_ready` rises in the first cycle after `rst` returns high.
  - Reset mid-run drops any pending pulse with no stop issued; the generator's own reset is expected to accompany it.
- All outputs are registered.
- Accept at edge T → ARM in T+1.
- `gen_ready` high at edge T in ARM → `gen_start` high during T+1 (first RUN cycle).
- With duration D and no abort, `gen_stop` is high exactly D+1 cycles after `gen_start`; `elapsed` = D at the stop.
- `gen_ready` seen in STOP at edge T → `done` high during T+1 → `cmd_ready` high during T+2.
- A command presented while busy is held off (`cmd_ready`=0) and not dropped.

## Configuration
- `FRAME_GEN_SEQ_FRAME_COUNT_EN`:
  - Defined: the frame counter and `aborted`-independent frame accounting are built as described.
  - Undefined: no counter logic is built, `frame_count` is tied to 0, and the `mon_*` inputs are unused.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then accept duration=10 with `gen_ready` held 1 → `gen_start` 2 cycles after accept; `gen_stop` 11 cycles after `gen_start`; `done` 1 cycle after `gen_stop`+1; `elapsed`=10.
- `gen_ready`=0 for 5 cycles in ARM, then 1 → `gen_start` delayed exactly 5 cycles; after stop hold `gen_ready`=0 for 7 cycles → `done` waits, `busy` stays 1.
- `abort` in ARM → no `gen_start`, `done` next cycle, `aborted`=1; `abort` at RUN `elapsed`=3 of duration 100 → `gen_stop` next cycle, `elapsed`=3, `aborted`=1.
- Duration 0 → `gen_start` and `gen_stop` on consecutive cycles, never overlapping; `elapsed`=0.
- With macro defined, drive 4 `last` beats in RUN and 2 in STOP, plus 3 in IDLE → `frame_count`=6. With CNT_WIDTH=4 and 20 frames → `frame_count` saturates at 15. Without macro → `frame_count`=0.
- Assert `rst`=0 mid-RUN → next cycle all outputs 0; new command accepted normally afterwards.
